// File: rtl/seq_detect_ctrl.sv
// Sequencing controller: latches a job word on start and streams it MSB-first
// through a Mealy pattern matcher, counting matches and recording the first hit.
module seq_detect_ctrl #(
  parameter int WORD_W = 16,
  parameter int PAT_W  = 3,
  parameter int CNT_W  = 5,
  localparam int IDX_W = $clog2(WORD_W)
) (
  input  logic              clk,
  input  logic              reset_n,
  // Handshake: start is a request sampled only in IDLE (acceptance is implicit,
  // no queueing); busy marks the WORD_W RUN cycles, done pulses once afterwards.
  input  logic              start_i,
  input  logic [WORD_W-1:0] data_in_i,
  input  logic [PAT_W-1:0]  pattern_i,
  input  logic              overlap_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              match_pulse_o,
  output logic [CNT_W-1:0]  match_count_o,
  output logic              found_o,
  output logic [IDX_W-1:0]  first_idx_o,
  output logic [1:0]        state_o
);

  localparam int SEEN_W = $clog2(PAT_W);
  localparam logic [SEEN_W-1:0] SEEN_MAX = SEEN_W'(PAT_W - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [PAT_W-1:0]    pat_q, pat_d;
  logic                ovl_q, ovl_d;
  logic [PAT_W-2:0]    hist_q, hist_d;
  logic [SEEN_W-1:0]   seen_q, seen_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                found_q, found_d;
  logic [IDX_W-1:0]    first_q, first_d;

  logic                cur_bit;
  logic [PAT_W-1:0]    cand;
  logic                match;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      pat_q   <= '0;
      ovl_q   <= 1'b0;
      hist_q  <= '0;
      seen_q  <= '0;
      idx_q   <= '0;
      count_q <= '0;
      found_q <= 1'b0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      seen_q  <= seen_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      found_q <= found_d;
      first_q <= first_d;
    end
  end

  // The word register shifts left each RUN cycle, so its MSB is always the current bit.
  assign cur_bit = word_q[WORD_W-1];
  assign cand    = {hist_q, cur_bit};

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    pat_d   = pat_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    seen_d  = seen_q;
    idx_d   = idx_q;
    count_d = count_q;
    found_d = found_q;
    first_d = first_q;
    match   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          word_d  = data_in_i;
          pat_d   = pattern_i;
          ovl_d   = overlap_i;
          hist_d  = '0;
          seen_d  = '0;
          idx_d   = '0;
          count_d = '0;
          found_d = 1'b0;
          first_d = '0;
        end
      end
      S_RUN: begin
        match  = (seen_q == SEEN_MAX) && (cand == pat_q);
        word_d = {word_q[WORD_W-2:0], 1'b0};
        hist_d = cand[PAT_W-2:0];
        idx_d  = idx_q + 1'b1;
        if (seen_q != SEEN_MAX) begin
          seen_d = seen_q + 1'b1;
        end
        if (match) begin
          if (count_q != {CNT_W{1'b1}}) begin
            count_d = count_q + 1'b1;
          end
          if (!found_q) begin
            found_d = 1'b1;
            first_d = idx_q;
          end
          // Without overlap the next match must be built from PAT_W fresh bits.
          if (!ovl_q) begin
            seen_d = '0;
          end
        end
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o        = (state_q == S_RUN);
  assign done_o        = (state_q == S_DONE);
  assign match_pulse_o = match;
  assign match_count_o = count_q;
  assign found_o       = found_q;
  assign first_idx_o   = first_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: directed scenarios plus random jobs checked against a
// sliding-window model of the pattern rules; a CNT_W=3 copy covers saturation.
module tb_seq_detect_ctrl;

  localparam int WORD_W = 16;
  localparam int PAT_W  = 3;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] data_in;
  logic [2:0]  pattern;
  logic        overlap;

  logic        busy, done, mp, found;
  logic [4:0]  mc;
  logic [3:0]  fi;
  logic [1:0]  st;
  logic        s_busy, s_done, s_mp, s_found;
  logic [2:0]  s_mc;
  logic [3:0]  s_fi;
  logic [1:0]  s_st;

  int checks;
  int failures;

  logic [15:0] obs_mask;
  int          obs_busy, obs_done_at, obs_stray, done_pulses;
  logic [4:0]  obs_cnt, obs_cnt_next;
  logic        obs_found, obs_found_next, obs_busy_next;
  logic [3:0]  obs_first;
  logic [2:0]  obs_scnt;
  logic [15:0] nxt_data;
  logic [2:0]  nxt_pat;
  logic        nxt_ovl;

  seq_detect_ctrl #(.WORD_W(16), .PAT_W(3), .CNT_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start), .data_in_i(data_in),
    .pattern_i(pattern), .overlap_i(overlap), .busy_o(busy), .done_o(done),
    .match_pulse_o(mp), .match_count_o(mc), .found_o(found), .first_idx_o(fi),
    .state_o(st)
  );

  seq_detect_ctrl #(.WORD_W(16), .PAT_W(3), .CNT_W(3)) dut_s (
    .clk(clk), .reset_n(reset_n), .start_i(start), .data_in_i(data_in),
    .pattern_i(pattern), .overlap_i(overlap), .busy_o(s_busy), .done_o(s_done),
    .match_pulse_o(s_mp), .match_count_o(s_mc), .found_o(s_found), .first_idx_o(s_fi),
    .state_o(s_st)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: scan the word, match any PAT_W-bit window lying entirely
  // after the last restart point; non-overlapping mode restarts after each hit.
  function automatic void model(input logic [15:0] w, input logic [2:0] p, input logic ov,
                                input int cap, output logic [15:0] mask, output int cnt,
                                output logic fnd, output int fst);
    int  restart;
    bit  ok;
    int  pos;
    mask = '0; cnt = 0; fnd = 1'b0; fst = 0; restart = 0;
    for (int idx = 0; idx < WORD_W; idx++) begin
      if (idx - restart >= PAT_W - 1) begin
        ok = 1'b1;
        for (int k = 0; k < PAT_W; k++) begin
          pos = idx - (PAT_W - 1) + k;
          if (w[WORD_W-1-pos] != p[PAT_W-1-k]) ok = 1'b0;
        end
        if (ok) begin
          mask[idx] = 1'b1;
          if (cnt < cap) cnt++;
          if (!fnd) begin fnd = 1'b1; fst = idx; end
          if (!ov) restart = idx + 1;
        end
      end
    end
  endfunction

  // Driver + monitor for one job; cycle c is c cycles after the accept cycle.
  task automatic run_job(input logic [15:0] d, input logic [2:0] p, input logic ov,
                         input bit hold);
    obs_mask = '0; obs_busy = 0; obs_done_at = -1; obs_stray = 0; done_pulses = 0;
    @(negedge clk);
    start = 1'b1; data_in = d; pattern = p; overlap = ov;
    @(posedge clk);
    for (int c = 1; c <= WORD_W + 3; c++) begin
      @(negedge clk);
      if (c <= WORD_W + 2) begin
        if (busy) obs_busy++;
        if (mp) begin
          if (busy && c <= WORD_W) obs_mask[c-1] = 1'b1;
          else obs_stray++;
        end
        if (done) begin
          done_pulses++; obs_done_at = c;
          obs_cnt = mc; obs_found = found; obs_first = fi; obs_scnt = s_mc;
        end
      end else begin
        obs_busy_next = busy; obs_cnt_next = mc; obs_found_next = found;
      end
      if (!hold) begin
        start = 1'b0;
      end else if (c <= WORD_W + 2) begin
        data_in = 16'($urandom); pattern = 3'($urandom); overlap = 1'($urandom);
        nxt_data = data_in; nxt_pat = pattern; nxt_ovl = overlap;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; data_in = '0; pattern = '0; overlap = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, mp, mc, found, fi} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0", {busy, done, mp, mc, found, fi});
    end
    checks++;
    if ({s_busy, s_done, s_mc, s_found, s_fi} !== 10'd0) begin
      failures++;
      $display("FAIL reset_outputs_small got=%b exp=0", {s_busy, s_done, s_mc, s_found, s_fi});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_overlap;
    run_job(16'hA805, 3'b101, 1'b1, 1'b0);
    checks++; if (obs_mask !== 16'h8014) begin failures++; $display("FAIL ovl_mask got=%h exp=8014", obs_mask); end
    checks++; if (obs_cnt !== 5'd3) begin failures++; $display("FAIL ovl_count got=%0d exp=3", obs_cnt); end
    checks++; if (obs_found !== 1'b1 || obs_first !== 4'd2) begin failures++; $display("FAIL ovl_first got=%b/%0d exp=1/2", obs_found, obs_first); end
    checks++; if (obs_done_at !== 17 || done_pulses !== 1) begin failures++; $display("FAIL ovl_done got=%0d/%0d exp=17/1", obs_done_at, done_pulses); end
    checks++; if (obs_busy !== 16 || obs_stray !== 0) begin failures++; $display("FAIL ovl_busy got=%0d/%0d exp=16/0", obs_busy, obs_stray); end
    checks++; if (obs_cnt_next !== 5'd3 || obs_found_next !== 1'b1 || obs_busy_next !== 1'b0) begin failures++; $display("FAIL ovl_stable got=%0d/%b/%b exp=3/1/0", obs_cnt_next, obs_found_next, obs_busy_next); end
  endtask

  task automatic test_no_overlap;
    run_job(16'hA805, 3'b101, 1'b0, 1'b0);
    checks++; if (obs_mask !== 16'h8004) begin failures++; $display("FAIL novl_mask got=%h exp=8004", obs_mask); end
    checks++; if (obs_cnt !== 5'd2 || obs_first !== 4'd2) begin failures++; $display("FAIL novl_result got=%0d/%0d exp=2/2", obs_cnt, obs_first); end
  endtask

  task automatic test_all_ones;
    run_job(16'hFFFF, 3'b111, 1'b1, 1'b0);
    checks++; if (obs_cnt !== 5'd14 || obs_mask !== 16'hFFFC) begin failures++; $display("FAIL ones_ovl got=%0d/%h exp=14/fffc", obs_cnt, obs_mask); end
    checks++; if (obs_scnt !== 3'd7 || s_fi !== 4'd2) begin failures++; $display("FAIL ones_sat got=%0d/%0d exp=7/2", obs_scnt, s_fi); end
    run_job(16'hFFFF, 3'b111, 1'b0, 1'b0);
    checks++; if (obs_cnt !== 5'd5 || obs_mask !== 16'h4924) begin failures++; $display("FAIL ones_novl got=%0d/%h exp=5/4924", obs_cnt, obs_mask); end
  endtask

  task automatic test_zero;
    run_job(16'h0000, 3'b101, 1'b1, 1'b0);
    checks++; if (obs_mask !== 16'h0 || obs_cnt !== 5'd0) begin failures++; $display("FAIL zero_count got=%h/%0d exp=0/0", obs_mask, obs_cnt); end
    checks++; if (obs_found !== 1'b0 || obs_first !== 4'd0) begin failures++; $display("FAIL zero_found got=%b/%0d exp=0/0", obs_found, obs_first); end
    checks++; if (obs_done_at !== 17) begin failures++; $display("FAIL zero_done got=%0d exp=17", obs_done_at); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] d, e_mask;
    logic [2:0]  p;
    logic        ov, e_fnd, got;
    int          e_cnt, e_fst;
    d = 16'($urandom); p = 3'($urandom); ov = 1'($urandom);
    model(d, p, ov, 31, e_mask, e_cnt, e_fnd, e_fst);
    run_job(d, p, ov, 1'b1);
    checks++; if (obs_mask !== e_mask || obs_cnt !== 5'(e_cnt)) begin failures++; $display("FAIL b2b_job1 got=%h/%0d exp=%h/%0d", obs_mask, obs_cnt, e_mask, e_cnt); end
    checks++; if (obs_busy !== 16 || done_pulses !== 1 || obs_done_at !== 17) begin failures++; $display("FAIL b2b_timing got=%0d/%0d/%0d exp=16/1/17", obs_busy, done_pulses, obs_done_at); end
    checks++; if (obs_busy_next !== 1'b1 || obs_cnt_next !== 5'd0 || obs_found_next !== 1'b0) begin failures++; $display("FAIL b2b_accept got=%b/%0d/%b exp=1/0/0", obs_busy_next, obs_cnt_next, obs_found_next); end
    start = 1'b0;
    model(nxt_data, nxt_pat, nxt_ovl, 31, e_mask, e_cnt, e_fnd, e_fst);
    got = 1'b0;
    for (int i = 0; i < WORD_W + 4 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    checks++;
    if (!got) begin failures++; $display("FAIL b2b_job2_timeout got=no_done exp=done"); end
    else if (mc !== 5'(e_cnt) || found !== e_fnd || fi !== 4'(e_fst)) begin
      failures++;
      $display("FAIL b2b_job2 got=%0d/%b/%0d exp=%0d/%b/%0d", mc, found, fi, e_cnt, e_fnd, e_fst);
    end
  endtask

  task automatic test_reset_midjob;
    int late_done;
    @(negedge clk);
    start = 1'b1; data_in = 16'hA805; pattern = 3'b101; overlap = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, mp, mc, found, fi} !== 13'd0) begin
      failures++;
      $display("FAIL midjob_reset got=%b exp=0", {busy, done, mp, mc, found, fi});
    end
    @(negedge clk);
    reset_n = 1'b1;
    late_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) late_done++;
    end
    checks++; if (late_done !== 0) begin failures++; $display("FAIL midjob_no_done got=%0d exp=0", late_done); end
    run_job(16'hA805, 3'b101, 1'b1, 1'b0);
    checks++; if (obs_mask !== 16'h8014 || obs_cnt !== 5'd3 || obs_first !== 4'd2) begin failures++; $display("FAIL midjob_rerun got=%h/%0d/%0d exp=8014/3/2", obs_mask, obs_cnt, obs_first); end
  endtask

  task automatic test_random;
    logic [15:0] d, e_mask, s_mask;
    logic [2:0]  p;
    logic        ov, e_fnd, s_fnd;
    int          e_cnt, e_fst, s_cnt, s_fst;
    for (int n = 0; n < 24; n++) begin
      d = 16'($urandom); p = 3'($urandom_range(0, 7)); ov = 1'($urandom_range(0, 1));
      if (n < 4) d = (n[0]) ? 16'hB6DB : 16'h5555;
      model(d, p, ov, 31, e_mask, e_cnt, e_fnd, e_fst);
      model(d, p, ov, 7, s_mask, s_cnt, s_fnd, s_fst);
      run_job(d, p, ov, 1'b0);
      checks++;
      if (obs_mask !== e_mask || obs_cnt !== 5'(e_cnt) || obs_found !== e_fnd || obs_first !== 4'(e_fst)) begin
        failures++;
        $display("FAIL rand_%0d d=%h p=%b ov=%b got=%h/%0d/%b/%0d exp=%h/%0d/%b/%0d", n, d, p, ov,
                 obs_mask, obs_cnt, obs_found, obs_first, e_mask, e_cnt, e_fnd, e_fst);
      end
      checks++;
      if (obs_scnt !== 3'(s_cnt) || obs_done_at !== 17 || obs_busy !== 16 || obs_stray !== 0) begin
        failures++;
        $display("FAIL rand_ctl_%0d got=%0d/%0d/%0d/%0d exp=%0d/17/16/0", n, obs_scnt, obs_done_at,
                 obs_busy, obs_stray, s_cnt);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_overlap();
    test_no_overlap();
    test_all_ones();
    test_zero();
    test_back_to_back();
    test_reset_midjob();
    test_random();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
